// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_WT, STREAM, DRAIN, DONE} ctrl_state_t;

    localparam int DEF_N_SIZE = 32;

    function automatic int array_latency(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/systolic_valid_pipe.sv
// DEPTH-stage valid shift register; vld_d is vld delayed by DEPTH cycles.
module systolic_valid_pipe #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    output logic vld_d
);

    logic [DEPTH-1:0] r_sr;
    logic [DEPTH-1:0] w_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_shift[gi] = vld;
            end else begin : g_body
                assign w_shift[gi] = r_sr[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_shift;
        end
    end

    assign vld_d = r_sr[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary systolic array sequencer: weight load, activation stream, drain.
// Optional SYSTOLIC_CTRL_PERF_EN adds busy-cycle and tile counters.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N_SIZE    = DEF_N_SIZE,
    parameter int M_MAX     = 256,
    parameter int ARRAY_LAT = array_latency(N_SIZE),
    parameter int ADDR_W    = 12,
    localparam int RW       = $clog2(M_MAX + 1),
    localparam int NW       = $clog2(N_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RW-1:0]     cfg_rows,
    input  logic              cfg_reuse_wt,
    input  logic [ADDR_W-1:0] cfg_wt_base,
    input  logic [ADDR_W-1:0] cfg_act_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    output logic              busy,
    output logic              done,
    output logic              wt_rd_en,
    output logic [ADDR_W-1:0] wt_rd_addr,
    output logic              arr_wt_en,
    output logic [NW-1:0]     arr_wt_row_sel,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              arr_valid_in,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [15:0]       perf_tiles
`endif
);

    ctrl_state_t       r_state, w_state_next;
    logic [RW-1:0]     r_rows, r_act_cnt, r_wr_cnt;
    logic [NW-1:0]     r_wt_cnt, r_row_sel;
    logic [ADDR_W-1:0] r_wt_base, r_act_base, r_out_base;
    logic              r_wt_en, r_valid, r_pre1, r_wr_en, r_done;
    logic              w_pre2, w_wt_rd, w_act_rd, w_accept, w_last_soon;
    logic [RW-1:0]     w_rows_sat;
    logic [RW+1:0]     w_wr_ahead;

    assign w_rows_sat = (cfg_rows > RW'(M_MAX)) ? RW'(M_MAX) : cfg_rows;
    assign w_accept   = (r_state == IDLE) && start;
    assign w_wt_rd    = (r_state == LOAD_WT);
    assign w_act_rd   = (r_state == STREAM);

    // Delay line totals ARRAY_LAT stages from the activation read strobe; the
    // last two stages are split out so DRAIN can see a write two cycles ahead
    // and leave DONE in time for the registered done to align with it.
    systolic_valid_pipe #(.DEPTH(ARRAY_LAT - 2)) u_valid_pipe (
        .clk   (clk),
        .rst   (rst),
        .vld   (w_act_rd),
        .vld_d (w_pre2)
    );

    // Writes issued by the end of next cycle, compared against the final index.
    assign w_wr_ahead  = {2'b00, r_wr_cnt} + (RW+2)'(r_wr_en) + (RW+2)'(r_pre1);
    assign w_last_soon = w_pre2 && ((w_wr_ahead + 1'b1) == {2'b00, r_rows});

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_rows_sat == '0)   w_state_next = DONE;
                    else if (cfg_reuse_wt)  w_state_next = STREAM;
                    else                    w_state_next = LOAD_WT;
                end
            end
            LOAD_WT: if (r_wt_cnt == NW'(N_SIZE - 1)) w_state_next = STREAM;
            STREAM:  if (r_act_cnt == r_rows - 1'b1)  w_state_next = DRAIN;
            DRAIN:   if (w_last_soon)                 w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rows     <= '0;
            r_act_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_wt_cnt   <= '0;
            r_row_sel  <= '0;
            r_wt_base  <= '0;
            r_act_base <= '0;
            r_out_base <= '0;
            r_wt_en    <= 1'b0;
            r_valid    <= 1'b0;
            r_pre1     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wt_en   <= w_wt_rd;
            r_row_sel <= w_wt_rd ? r_wt_cnt : '0;
            r_valid   <= w_act_rd;
            r_pre1    <= w_pre2;
            r_wr_en   <= r_pre1;
            r_done    <= (r_state == DONE);
            if (w_accept) begin
                r_rows     <= w_rows_sat;
                r_wt_base  <= cfg_wt_base;
                r_act_base <= cfg_act_base;
                r_out_base <= cfg_out_base;
                r_wt_cnt   <= '0;
                r_act_cnt  <= '0;
                r_wr_cnt   <= '0;
            end else begin
                if (w_wt_rd) r_wt_cnt <= (r_wt_cnt == NW'(N_SIZE - 1)) ? '0 : r_wt_cnt + 1'b1;
                if (w_act_rd) r_act_cnt <= r_act_cnt + 1'b1;
                if (r_wr_en) r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign wt_rd_en       = w_wt_rd;
    assign wt_rd_addr     = w_wt_rd ? r_wt_base + ADDR_W'(r_wt_cnt) : '0;
    assign arr_wt_en      = r_wt_en;
    assign arr_wt_row_sel = r_row_sel;
    assign act_rd_en      = w_act_rd;
    assign act_rd_addr    = w_act_rd ? r_act_base + ADDR_W'(r_act_cnt) : '0;
    assign arr_valid_in   = r_valid;
    assign out_wr_en      = r_wr_en;
    assign out_wr_addr    = r_wr_en ? r_out_base + ADDR_W'(r_wr_cnt) : '0;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] r_perf_busy;
    logic [15:0] r_perf_tiles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_busy  <= '0;
            r_perf_tiles <= '0;
        end else begin
            if (busy && (r_perf_busy != '1))   r_perf_busy  <= r_perf_busy + 1'b1;
            if (r_done && (r_perf_tiles != '1)) r_perf_tiles <= r_perf_tiles + 1'b1;
        end
    end

    assign perf_busy_cycles = r_perf_busy;
    assign perf_tiles       = r_perf_tiles;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: directed and random tiles against a cycle-offset model.
module tb_systolic_ctrl;

    localparam int N   = 4;
    localparam int LAT = 8;
    localparam int MM  = 6;
    localparam int AW  = 12;
    localparam int RW  = $clog2(MM + 1);
    localparam int SW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] cfg_rows = '0;
    logic          cfg_reuse_wt = 1'b0;
    logic [AW-1:0] cfg_wt_base = '0, cfg_act_base = '0, cfg_out_base = '0;
    logic          busy, done, wt_rd_en, arr_wt_en, act_rd_en, arr_valid_in, out_wr_en;
    logic [AW-1:0] wt_rd_addr, act_rd_addr, out_wr_addr;
    logic [SW-1:0] arr_wt_row_sel;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [15:0]   perf_tiles;
`endif

    int n_total = 0;
    int n_fail  = 0;
    int exp_busy_cycles = 0;
    int exp_tiles = 0;

    systolic_ctrl #(.N_SIZE(N), .M_MAX(MM), .ARRAY_LAT(LAT), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_rows       (cfg_rows),
        .cfg_reuse_wt   (cfg_reuse_wt),
        .cfg_wt_base    (cfg_wt_base),
        .cfg_act_base   (cfg_act_base),
        .cfg_out_base   (cfg_out_base),
        .busy           (busy),
        .done           (done),
        .wt_rd_en       (wt_rd_en),
        .wt_rd_addr     (wt_rd_addr),
        .arr_wt_en      (arr_wt_en),
        .arr_wt_row_sel (arr_wt_row_sel),
        .act_rd_en      (act_rd_en),
        .act_rd_addr    (act_rd_addr),
        .arr_valid_in   (arr_valid_in),
        .out_wr_en      (out_wr_en),
        .out_wr_addr    (out_wr_addr)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_tiles       (perf_tiles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int off, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s off=%0d got=0x%0h want=0x%0h", tag, off, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input int off);
        check({tag, ".busy"},      off, 32'(busy), 0);
        check({tag, ".done"},      off, 32'(done), 0);
        check({tag, ".wt_rd_en"},  off, 32'(wt_rd_en), 0);
        check({tag, ".wt_addr"},   off, 32'(wt_rd_addr), 0);
        check({tag, ".arr_wt_en"}, off, 32'(arr_wt_en), 0);
        check({tag, ".row_sel"},   off, 32'(arr_wt_row_sel), 0);
        check({tag, ".act_rd_en"}, off, 32'(act_rd_en), 0);
        check({tag, ".act_addr"},  off, 32'(act_rd_addr), 0);
        check({tag, ".valid_in"},  off, 32'(arr_valid_in), 0);
        check({tag, ".out_wr_en"}, off, 32'(out_wr_en), 0);
        check({tag, ".out_addr"},  off, 32'(out_wr_addr), 0);
    endtask

    // Expected outputs derived from offsets relative to the start cycle.
    task automatic run_tile(input int rows, input bit reuse, input logic [AW-1:0] wb,
                            input logic [AW-1:0] ab, input logic [AW-1:0] ob,
                            input int mid_off, input int rst_off);
        int m, lw, done_off, n_wr;
        bit ld, e_wt, e_awt, e_act, e_vld, e_wr;
        logic [AW-1:0] a_wt, a_act, a_out;
        m        = (rows > MM) ? MM : rows;
        ld       = !reuse && (m > 0);
        lw       = ld ? N : 0;
        done_off = (m == 0) ? 2 : lw + m + LAT;
        n_wr     = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_rows = RW'(rows);
        cfg_reuse_wt = reuse;
        cfg_wt_base = wb;
        cfg_act_base = ab;
        cfg_out_base = ob;
        for (int o = 1; o <= done_off + 1; o++) begin
            @(negedge clk);
            e_wt  = ld && (o >= 1) && (o <= N);
            e_awt = ld && (o >= 2) && (o <= N + 1);
            e_act = (m > 0) && (o >= lw + 1) && (o <= lw + m);
            e_vld = (m > 0) && (o >= lw + 2) && (o <= lw + m + 1);
            e_wr  = (m > 0) && (o >= lw + 1 + LAT) && (o <= lw + m + LAT);
            a_wt  = e_wt  ? wb + AW'(o - 1) : '0;
            a_act = e_act ? ab + AW'(o - lw - 1) : '0;
            a_out = e_wr  ? ob + AW'(o - lw - 1 - LAT) : '0;
            if (out_wr_en === 1'b1) n_wr++;
            check("busy",      o, 32'(busy), 32'(o < done_off));
            check("done",      o, 32'(done), 32'(o == done_off));
            check("wt_rd_en",  o, 32'(wt_rd_en), 32'(e_wt));
            check("wt_addr",   o, 32'(wt_rd_addr), 32'(a_wt));
            check("arr_wt_en", o, 32'(arr_wt_en), 32'(e_awt));
            check("row_sel",   o, 32'(arr_wt_row_sel), e_awt ? 32'(o - 2) : 0);
            check("act_rd_en", o, 32'(act_rd_en), 32'(e_act));
            check("act_addr",  o, 32'(act_rd_addr), 32'(a_act));
            check("valid_in",  o, 32'(arr_valid_in), 32'(e_vld));
            check("out_wr_en", o, 32'(out_wr_en), 32'(e_wr));
            check("out_addr",  o, 32'(out_wr_addr), 32'(a_out));
            start = (mid_off > 0) && (o == mid_off);
            if (start) begin
                cfg_rows     = RW'($urandom_range(1, MM));
                cfg_reuse_wt = ~reuse;
                cfg_wt_base  = AW'($urandom);
                cfg_act_base = AW'($urandom);
                cfg_out_base = AW'($urandom);
            end
            if (o == rst_off) begin
                #2 rst = 1'b1;
                #1 check_all_zero("async_rst", o);
                @(negedge clk);
                @(negedge clk);
                check_all_zero("held_rst", o);
                rst = 1'b0;
                exp_busy_cycles = 0;
                exp_tiles = 0;
                $display("tile rows=%0d reuse=%0d reset at off=%0d", rows, reuse, o);
                return;
            end
        end
        check("write_count", done_off, 32'(n_wr), 32'(m));
        exp_busy_cycles += done_off - 1;
        exp_tiles++;
        $display("tile rows=%0d reuse=%0d wt=%0h act=%0h out=%0h done_off=%0d writes=%0d",
                 rows, reuse, wb, ab, ob, done_off, n_wr);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset", 0);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle", 0);

        run_tile(4, 1'b0, 12'h100, 12'h200, 12'h300, 0, 0);
        run_tile(4, 1'b1, 12'h100, 12'h200, 12'h300, 0, 0);
        run_tile(0, 1'b0, 12'h100, 12'h200, 12'h300, 0, 0);
        run_tile(0, 1'b1, 12'h111, 12'h222, 12'h333, 0, 0);
        run_tile(4, 1'b0, 12'h100, 12'h200, 12'h300, N + 2, 0);
        run_tile(4, 1'b0, 12'h100, 12'h200, 12'h300, 0, N + 2);
        @(negedge clk);
        check_all_zero("post_rst", 0);
        run_tile(4, 1'b0, 12'h100, 12'h200, 12'h300, 0, 0);
        run_tile(4, 1'b1, 12'h040, 12'h050, 12'hFFE, 0, 0);
        run_tile(7, 1'b1, 12'hFFF, 12'hFFD, 12'h010, 0, 0);
        run_tile(1, 1'b0, 12'hFFE, 12'h000, 12'hFFF, 0, 0);

        for (int t = 0; t < 10; t++) begin
            run_tile(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     AW'($urandom), AW'($urandom), AW'($urandom),
                     (t % 3 == 1) ? 3 : 0, 0);
        end

`ifdef SYSTOLIC_CTRL_PERF_EN
        @(negedge clk);
        check("perf_busy",  0, perf_busy_cycles, 32'(exp_busy_cycles));
        check("perf_tiles", 0, 32'(perf_tiles), 32'(exp_tiles));
`endif

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
